fcc_page_arbiter: RTL and testbench
===================================

# fcc_page_arbiter

Shares one `fcc_executer` between up to eight per-way `fcc_scheduler` instances in `fcc_core`. It collects page commands from the requesters and grants the executer to one at a time, round-robin. It presents the granted command on the executer's `i_cmd_valid`/`i_cmd*` inputs and tracks the executer's `o_cmd_ready` through acceptance and completion. A watchdog releases a grant that the executer never accepts.

## Interface
Parameters:
- `REQ_NUM`, 4 — number of requesters, 1..8.
- `TIMEOUT`, 256 — max cycles in ISSUE awaiting acceptance, ≥2, ≤65535.

Packed page command, `PC_W` = 178 bits, fixed. Layout `{type[1:0], param[31:0], data[63:0], addr[47:0], id[15:0], cmd[15:0]}`.

Ports:
- `usr_clk`  in  1  — single clock.
- `usr_rst`  in  1  — reset, synchronous, active-high.
- `i_req_valid`  in  REQ_NUM  — requester k holds a page command.
- `i_req_cmd`  in  REQ_NUM*178  — requester k command at `[k*178 +: 178]`.
- `o_req_ack`  out  REQ_NUM  — one-cycle pulse: requester k's command was accepted by the executer.
- `o_exec_valid`  out  1  — to executer `i_cmd_valid`.
- `o_exec_cmd`  out  178  — latched command to executer fields.
- `i_exec_ready`  in  1  — executer `o_cmd_ready`.
- `o_grant`  out  REQ_NUM  — one-hot current owner; 0 in IDLE.
- `o_grant_idx`  out  3  — index of current/last owner.
- `o_busy`  out  1  — state ≠ IDLE.
- `o_done`  out  1  — one-cycle pulse on command completion.
- `o_timeout`  out  1  — one-cycle pulse on watchdog release.

## Operation
- State machine: IDLE → ISSUE → BUSY → IDLE; ISSUE → IDLE on timeout.
- **IDLE**
  - Triggers when `i_exec_ready`=1 and any `i_req_valid` bit is set.
  - Picks g = first valid index scanning `rr_ptr`, `rr_ptr`+1, … modulo REQ_NUM.
  - Latches `i_req_cmd[g]` into `o_exec_cmd`, sets `o_grant`=1<<g and `o_grant_idx`=g, then enters ISSUE.
  - If `i_exec_ready`=0, it stays in IDLE; requests are not consumed.
- **ISSUE**
  - `o_exec_valid`=1 and the watchdog counter increments each cycle.
  - `i_exec_ready`=0 sampled → acceptance: BUSY, `o_exec_valid`←0, `o_req_ack[g]` pulse.
  - Else, if counter = TIMEOUT−1 → IDLE, `o_exec_valid`←0, `o_timeout` pulse, `o_grant`←0, `rr_ptr`←g+1. No ack is given; the requester keeps its valid.
- **BUSY**
  - Waits for `i_exec_ready`=1, then → IDLE with `o_done` pulse, `o_grant`←0, `rr_ptr`←g+1.
  - No watchdog in BUSY, because NAND operations are unbounded.
- `rr_ptr` is 3 bits and wraps REQ_NUM−1 → 0. With REQ_NUM=1 it stays 0.
- Requester rule: hold `i_req_valid` and the command stable until `o_req_ack`, and drop valid by the cycle after the ack.
  - The arbiter ignores non-granted changes.
  - Withdrawal during ISSUE is not supported.
- `o_exec_cmd` holds its value after release; it only changes at a new grant.

## Timing
- Reset values, taking effect at the first edge with `usr_rst`=1:
  - state = IDLE;
  - `o_exec_valid`, `o_req_ack`, `o_grant`, `o_busy`, `o_done`, `o_timeout` = 0;
  - `o_exec_cmd` = 0, `o_grant_idx` = 0, `rr_ptr` = 0, counter = 0.
- Reset mid-operation aborts immediately with no ack, done or timeout pulse.
- Latency from a request sampled in IDLE at edge t: `o_exec_valid`=1 and `o_grant` set from t+1.
- Acceptance: `i_exec_ready`=0 sampled at edge a → `o_exec_valid`=0 and `o_req_ack` high for exactly cycle a+1.
- Completion: `i_exec_ready`=1 sampled in BUSY at edge c → `o_done` high for cycle c+1 and IDLE from c+1. The earliest next grant is visible at c+2.
- Watchdog: with `i_exec_ready` held at 1, `o_exec_valid` is high for exactly TIMEOUT cycles.
- Acceptance and timeout in the same cycle: acceptance wins.
- All outputs are registered.

## Test plan
- **Single request.** REQ_NUM=4, request on k=2 with cmd=16'h0030, addr=48'h1234; executer ready drops 2 cycles after valid and rises 10 cycles later → `o_exec_cmd` equals `i_req_cmd[2]`; `o_req_ack`=4'b0100 for one cycle; one `o_done` pulse; `o_busy` spans 13 cycles.
- **Round robin.** All 4 requesters valid continuously, executer model acks each in 3 cycles → grant order 0,1,2,3,0,1; each `o_grant` is one-hot.
- **Watchdog.** TIMEOUT=16, `i_exec_ready` stuck at 1, requesters 0 and 1 valid → `o_exec_valid` high 16 cycles; `o_timeout` pulses; no ack; next grant goes to requester 1.
- **Executer busy.** `i_exec_ready`=0 while a request arrives → stays IDLE with `o_exec_valid`=0; grant occurs 1 cycle after ready rises.
- **Reset mid-BUSY.** Assert `usr_rst` mid-BUSY → all outputs reach reset values at the next edge; after release, the first grant goes to the lowest valid index.
- **Command latch.** Requester changes its command fields after ack → `o_exec_cmd` is unchanged until the next grant.

Source files
------------

// File: rtl/fcc_page_arbiter.sv
// fcc_page_arbiter: shares one fcc_executer between REQ_NUM fcc_scheduler requesters.
// Latency: request sampled in IDLE at edge t -> o_exec_valid/o_grant visible from t+1.
// Backpressure: no grant while i_exec_ready=0; requests are held by the requester until o_req_ack.
//
// Ports:
//   usr_clk, usr_rst       clock, synchronous active-high reset
//   i_req_valid/i_req_cmd  per-requester page command (k at [k*178 +: 178])
//   o_req_ack              one-cycle pulse when requester k's command is accepted
//   o_exec_valid/o_exec_cmd  command presented to the executer (cmd held after release)
//   i_exec_ready           executer o_cmd_ready: 0 = accepted / working, 1 = idle
//   o_grant/o_grant_idx    one-hot current owner / index of current or last owner
//   o_busy/o_done/o_timeout  status and one-cycle completion / watchdog pulses
//
// Page command layout: {type[1:0], param[31:0], data[63:0], addr[47:0], id[15:0], cmd[15:0]}.

module fcc_page_arbiter #(
  parameter int unsigned REQ_NUM = 4,
  parameter int unsigned TIMEOUT = 256,
  localparam int unsigned PC_W   = 178
) (
  input  logic                      usr_clk,
  input  logic                      usr_rst,
  input  logic [REQ_NUM-1:0]        i_req_valid,
  input  logic [REQ_NUM*PC_W-1:0]   i_req_cmd,
  output logic [REQ_NUM-1:0]        o_req_ack,
  output logic                      o_exec_valid,
  output logic [PC_W-1:0]           o_exec_cmd,
  input  logic                      i_exec_ready,
  output logic [REQ_NUM-1:0]        o_grant,
  output logic [2:0]                o_grant_idx,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // Last count value spent in ISSUE before the watchdog fires; the counter
  // starts at 0 on the first ISSUE cycle, so the command is offered TIMEOUT cycles.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q,      state_d;
  logic                  exec_valid_q, exec_valid_d;
  logic [PC_W-1:0]       exec_cmd_q,   exec_cmd_d;
  logic [REQ_NUM-1:0]    ack_q,        ack_d;
  logic [REQ_NUM-1:0]    grant_q,      grant_d;
  logic [2:0]            grant_idx_q,  grant_idx_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;
  logic                  timeout_q,    timeout_d;
  logic [2:0]            rr_q,         rr_d;
  logic [15:0]           cnt_q,        cnt_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester at or after rr_q, wrapping at REQ_NUM.
  // The valid vector is padded to 8 bits so a 3-bit index always fits.
  // ---------------------------------------------------------------------------
  logic [7:0]            req_valid_pad;
  logic [3:0]            scan_idx;
  logic                  pick_found;
  logic [2:0]            pick_idx;
  logic [PC_W-1:0]       pick_cmd;
  logic [REQ_NUM-1:0]    pick_onehot;

  assign req_valid_pad = 8'(i_req_valid);

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    scan_idx   = 4'd0;
    for (int s = 0; s < REQ_NUM; s++) begin
      // rr_q < REQ_NUM and s < REQ_NUM, so a single subtraction wraps correctly.
      scan_idx = {1'b0, rr_q} + 4'(s);
      if (scan_idx >= 4'(REQ_NUM)) begin
        scan_idx = scan_idx - 4'(REQ_NUM);
      end
      if (!pick_found && req_valid_pad[scan_idx[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[2:0];
      end
    end
  end

  // Command mux and one-hot grant for the picked requester.
  always_comb begin
    pick_cmd    = '0;
    pick_onehot = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (3'(k) == pick_idx) begin
        pick_cmd       = i_req_cmd[k*PC_W +: PC_W];
        pick_onehot[k] = 1'b1;
      end
    end
  end

  // Pointer after the owner releases: one past the owner, wrapping to 0.
  logic [2:0] rr_after_owner;

  always_comb begin
    if (grant_idx_q >= 3'(REQ_NUM - 1)) begin
      rr_after_owner = 3'd0;
    end else begin
      rr_after_owner = grant_idx_q + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    exec_valid_d = exec_valid_q;
    exec_cmd_d   = exec_cmd_q;
    ack_d        = '0;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    rr_d         = rr_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Only grant when the executer reports idle; otherwise leave requests pending.
        if (i_exec_ready && pick_found) begin
          state_d      = ST_ISSUE;
          exec_valid_d = 1'b1;
          exec_cmd_d   = pick_cmd;
          grant_d      = pick_onehot;
          grant_idx_d  = pick_idx;
          cnt_d        = 16'd0;
        end
      end

      ST_ISSUE: begin
        // The executer drops ready when it takes the command; this wins over
        // a watchdog expiry in the same cycle.
        if (!i_exec_ready) begin
          state_d      = ST_BUSY;
          exec_valid_d = 1'b0;
          ack_d        = grant_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          exec_valid_d = 1'b0;
          timeout_d    = 1'b1;
          grant_d      = '0;
          rr_d         = rr_after_owner;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_BUSY: begin
        // NAND operations have no upper bound, so no watchdog here.
        if (i_exec_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          grant_d = '0;
          rr_d    = rr_after_owner;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        exec_valid_d = 1'b0;
        grant_d      = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge usr_clk) begin
    if (usr_rst) begin
      state_q      <= ST_IDLE;
      exec_valid_q <= 1'b0;
      exec_cmd_q   <= '0;
      ack_q        <= '0;
      grant_q      <= '0;
      grant_idx_q  <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      rr_q         <= 3'd0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      exec_valid_q <= exec_valid_d;
      exec_cmd_q   <= exec_cmd_d;
      ack_q        <= ack_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_exec_valid = exec_valid_q;
  assign o_exec_cmd   = exec_cmd_q;
  assign o_req_ack    = ack_q;
  assign o_grant      = grant_q;
  assign o_grant_idx  = grant_idx_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_fcc_page_arbiter.sv
// Testbench for fcc_page_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level model of the arbiter.
module tb_fcc_page_arbiter;

  localparam int REQ  = 4;
  localparam int TO   = 16;
  localparam int PC_W = 178;

  logic                  usr_clk;
  logic                  usr_rst;
  logic [REQ-1:0]        req_valid;
  logic [REQ*PC_W-1:0]   req_cmd;
  logic [REQ-1:0]        req_ack;
  logic                  exec_valid;
  logic [PC_W-1:0]       exec_cmd;
  logic                  exec_ready;
  logic [REQ-1:0]        grant;
  logic [2:0]            grant_idx;
  logic                  busy;
  logic                  done;
  logic                  tmo;

  int n_checks = 0;
  int n_pass   = 0;

  fcc_page_arbiter #(.REQ_NUM(REQ), .TIMEOUT(TO)) dut (
    .usr_clk      (usr_clk),
    .usr_rst      (usr_rst),
    .i_req_valid  (req_valid),
    .i_req_cmd    (req_cmd),
    .o_req_ack    (req_ack),
    .o_exec_valid (exec_valid),
    .o_exec_cmd   (exec_cmd),
    .i_exec_ready (exec_ready),
    .o_grant      (grant),
    .o_grant_idx  (grant_idx),
    .o_busy       (busy),
    .o_done       (done),
    .o_timeout    (tmo)
  );

  initial usr_clk = 1'b0;
  always #5 usr_clk = ~usr_clk;

  // Inputs are driven and outputs observed right after the falling edge.
  task automatic cyc();
    @(negedge usr_clk);
  endtask

  function automatic logic [PC_W-1:0] rand_cmd();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[PC_W-1:0];
  endfunction

  task automatic do_reset();
    usr_rst    = 1'b1;
    req_valid  = '0;
    exec_ready = 1'b1;
    cyc();
    cyc();
    usr_rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks the owner as an integer (-1 = none), whether the
  // executer has taken the command, and how long it has been offered.
  // ---------------------------------------------------------------------------
  int              m_owner;
  int              m_age;
  int              m_rr;
  bit              m_acc;
  logic [REQ-1:0]  e_ack;
  logic            e_done;
  logic            e_to;
  logic [2:0]      e_idx;
  logic [PC_W-1:0] e_cmd;

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_rr = 0; m_acc = 0;
    e_ack = '0; e_done = 0; e_to = 0; e_idx = 0; e_cmd = '0;
  endtask

  // Predicts the outputs after the next rising edge from the current inputs.
  task automatic model_step();
    e_ack = '0; e_done = 0; e_to = 0;
    if (m_owner < 0) begin
      if (exec_ready && req_valid != 0) begin
        for (int s = 0; s < REQ; s++)
          if (m_owner < 0 && req_valid[(m_rr + s) % REQ]) m_owner = (m_rr + s) % REQ;
        m_acc = 0;
        m_age = 0;
        e_idx = 3'(m_owner);
        e_cmd = req_cmd[m_owner*PC_W +: PC_W];
      end
    end else if (!m_acc) begin
      if (!exec_ready) begin
        m_acc = 1;
        e_ack = REQ'(1 << m_owner);
      end else if (m_age == TO - 1) begin
        e_to    = 1;
        m_rr    = (m_owner + 1) % REQ;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else if (exec_ready) begin
      e_done  = 1;
      m_rr    = (m_owner + 1) % REQ;
      m_owner = -1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    usr_rst    = 1'b1;
    exec_ready = 1'b1;
    req_valid  = '1;
    for (int k = 0; k < REQ; k++) req_cmd[k*PC_W +: PC_W] = rand_cmd();
    cyc();
    cyc();
    n_checks++; if (exec_valid !== 1'b0) $display("FAIL reset_exec_valid got %b want 0", exec_valid); else n_pass++;
    n_checks++; if (req_ack !== '0) $display("FAIL reset_ack got %b want 0", req_ack); else n_pass++;
    n_checks++; if (grant !== '0) $display("FAIL reset_grant got %b want 0", grant); else n_pass++;
    n_checks++; if (grant_idx !== 3'd0) $display("FAIL reset_grant_idx got %0d want 0", grant_idx); else n_pass++;
    n_checks++; if ({busy, done, tmo} !== 3'b000) $display("FAIL reset_status got %b want 000", {busy, done, tmo}); else n_pass++;
    n_checks++; if (exec_cmd !== '0) $display("FAIL reset_exec_cmd got %h want 0", exec_cmd); else n_pass++;
    usr_rst   = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    logic [PC_W-1:0] c;
    int busy_cnt, done_cnt, ack_cnt, valid_cnt;
    do_reset();
    c = rand_cmd();
    c[15:0]  = 16'h0030;
    c[79:32] = 48'h1234;
    req_cmd[2*PC_W +: PC_W] = c;
    req_valid  = 4'b0100;
    exec_ready = 1'b1;
    busy_cnt = 0; done_cnt = 0; ack_cnt = 0; valid_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 1) begin
        n_checks++; if (grant !== 4'b0100 || grant_idx !== 3'd2) $display("FAIL single_grant got %b/%0d want 0100/2", grant, grant_idx); else n_pass++;
        n_checks++; if (exec_cmd !== c) $display("FAIL single_cmd got %h want %h", exec_cmd, c); else n_pass++;
      end
      if (req_ack != 0) begin
        ack_cnt++;
        n_checks++; if (req_ack !== 4'b0100) $display("FAIL single_ack got %b want 0100", req_ack); else n_pass++;
        req_valid = '0;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (exec_valid) valid_cnt++;
      if (i == 3)  exec_ready = 1'b0;
      if (i == 13) exec_ready = 1'b1;
    end
    n_checks++; if (ack_cnt !== 1) $display("FAIL single_ack_count got %0d want 1", ack_cnt); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL single_done_count got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (busy_cnt !== 13) $display("FAIL single_busy_cycles got %0d want 13", busy_cnt); else n_pass++;
    n_checks++; if (valid_cnt !== 3) $display("FAIL single_valid_cycles got %0d want 3", valid_cnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    int ngr, vcnt, bcnt;
    logic prev_valid;
    do_reset();
    for (int k = 0; k < REQ; k++) req_cmd[k*PC_W +: PC_W] = rand_cmd();
    req_valid  = '1;
    exec_ready = 1'b1;
    ngr = 0; vcnt = 0; bcnt = 0; prev_valid = 1'b0;
    for (int i = 0; i < 200 && ngr < 6; i++) begin
      cyc();
      if (exec_valid) begin
        if (!prev_valid) begin
          n_checks++; if (grant !== REQ'(1 << (ngr % REQ)) || grant_idx !== 3'(ngr % REQ)) $display("FAIL rr_order[%0d] got %b/%0d want idx %0d", ngr, grant, grant_idx, ngr % REQ); else n_pass++;
          n_checks++; if (!$onehot(grant)) $display("FAIL rr_onehot[%0d] got %b want one-hot", ngr, grant); else n_pass++;
          ngr++;
          vcnt = 0;
          bcnt = 0;
        end
        vcnt++;
        if (vcnt == 3) exec_ready = 1'b0;
      end else if (busy) begin
        bcnt++;
        if (bcnt == 2) exec_ready = 1'b1;
      end
      prev_valid = exec_valid;
    end
    n_checks++; if (ngr !== 6) $display("FAIL rr_grant_count got %0d want 6", ngr); else n_pass++;
  endtask

  task automatic test_watchdog();
    int vcnt, acks, guard;
    do_reset();
    req_cmd[0 +: PC_W]    = rand_cmd();
    req_cmd[PC_W +: PC_W] = rand_cmd();
    req_valid  = 4'b0011;
    exec_ready = 1'b1;
    cyc();
    n_checks++; if (grant !== 4'b0001) $display("FAIL wd_first_grant got %b want 0001", grant); else n_pass++;
    vcnt = 0; acks = 0; guard = 0;
    while (exec_valid === 1'b1 && guard < 40) begin
      vcnt++;
      if (req_ack != 0) acks++;
      cyc();
      guard++;
    end
    n_checks++; if (vcnt !== TO) $display("FAIL wd_valid_cycles got %0d want %0d", vcnt, TO); else n_pass++;
    n_checks++; if (tmo !== 1'b1) $display("FAIL wd_timeout_pulse got %b want 1", tmo); else n_pass++;
    n_checks++; if (grant !== '0 || busy !== 1'b0) $display("FAIL wd_release got grant %b busy %b want 0 0", grant, busy); else n_pass++;
    n_checks++; if (acks !== 0 || req_ack !== '0) $display("FAIL wd_no_ack got %0d acks want 0", acks); else n_pass++;
    cyc();
    n_checks++; if (tmo !== 1'b0) $display("FAIL wd_timeout_width got %b want 0", tmo); else n_pass++;
    n_checks++; if (grant !== 4'b0010 || grant_idx !== 3'd1 || exec_valid !== 1'b1) $display("FAIL wd_next_grant got %b/%0d valid %b want 0010/1 1", grant, grant_idx, exec_valid); else n_pass++;
  endtask

  task automatic test_exec_busy();
    do_reset();
    exec_ready = 1'b0;
    req_cmd[3*PC_W +: PC_W] = rand_cmd();
    req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++; if (exec_valid !== 1'b0 || busy !== 1'b0) $display("FAIL xbusy_hold[%0d] got valid %b busy %b want 0 0", i, exec_valid, busy); else n_pass++;
    end
    exec_ready = 1'b1;
    cyc();
    n_checks++; if (exec_valid !== 1'b1 || grant !== 4'b1000) $display("FAIL xbusy_grant got valid %b grant %b want 1 1000", exec_valid, grant); else n_pass++;
    exec_ready = 1'b0;
    cyc();
    req_valid  = '0;
    exec_ready = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    for (int k = 0; k < REQ; k++) req_cmd[k*PC_W +: PC_W] = rand_cmd();
    req_valid  = 4'b0010;
    exec_ready = 1'b1;
    cyc();
    exec_ready = 1'b0;
    cyc();
    req_valid  = '0;
    exec_ready = 1'b1;
    cyc();
    cyc();
    req_valid = 4'b0100;
    cyc();
    exec_ready = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b1 || grant_idx !== 3'd2 || exec_valid !== 1'b0) $display("FAIL rstbusy_setup got busy %b idx %0d want 1 2", busy, grant_idx); else n_pass++;
    req_valid  = 4'b1110;
    exec_ready = 1'b1;
    usr_rst    = 1'b1;
    cyc();
    n_checks++; if ({exec_valid, req_ack, grant, grant_idx, busy, done, tmo} !== '0) $display("FAIL rstbusy_outputs got %b want 0", {exec_valid, req_ack, grant, grant_idx, busy, done, tmo}); else n_pass++;
    n_checks++; if (exec_cmd !== '0) $display("FAIL rstbusy_cmd got %h want 0", exec_cmd); else n_pass++;
    usr_rst = 1'b0;
    cyc();
    n_checks++; if (grant !== 4'b0010 || grant_idx !== 3'd1) $display("FAIL rstbusy_first_grant got %b/%0d want 0010/1", grant, grant_idx); else n_pass++;
  endtask

  task automatic test_cmd_latch();
    logic [PC_W-1:0] a, b;
    do_reset();
    a = rand_cmd();
    b = ~a;
    req_cmd[0 +: PC_W] = a;
    req_valid  = 4'b0001;
    exec_ready = 1'b1;
    cyc();
    n_checks++; if (exec_cmd !== a) $display("FAIL latch_grant_cmd got %h want %h", exec_cmd, a); else n_pass++;
    exec_ready = 1'b0;
    cyc();
    req_cmd[0 +: PC_W] = b;
    req_valid = '0;
    cyc();
    n_checks++; if (exec_cmd !== a) $display("FAIL latch_busy_cmd got %h want %h", exec_cmd, a); else n_pass++;
    exec_ready = 1'b1;
    cyc();
    n_checks++; if (done !== 1'b1 || exec_cmd !== a) $display("FAIL latch_done got done %b cmd %h want 1 %h", done, exec_cmd, a); else n_pass++;
    cyc();
    cyc();
    n_checks++; if (exec_cmd !== a) $display("FAIL latch_idle_cmd got %h want %h", exec_cmd, a); else n_pass++;
    req_valid = 4'b0001;
    cyc();
    n_checks++; if (exec_cmd !== b) $display("FAIL latch_new_cmd got %h want %h", exec_cmd, b); else n_pass++;
  endtask

  task automatic test_random();
    logic [14:0] exp_ctl;
    do_reset();
    model_reset();
    req_valid  = '0;
    exec_ready = 1'b1;
    model_step();
    for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
      cyc();
      exp_ctl = {(m_owner >= 0 && !m_acc), e_ack,
                 (m_owner >= 0) ? REQ'(1 << m_owner) : REQ'(0),
                 e_idx, (m_owner >= 0), e_done, e_to};
      n_checks++; if ({exec_valid, req_ack, grant, grant_idx, busy, done, tmo} !== exp_ctl) $display("FAIL rand_ctl@%0d got %b want %b", cyc_n, {exec_valid, req_ack, grant, grant_idx, busy, done, tmo}, exp_ctl); else n_pass++;
      n_checks++; if (exec_cmd !== e_cmd) $display("FAIL rand_cmd@%0d got %h want %h", cyc_n, exec_cmd, e_cmd); else n_pass++;
      for (int k = 0; k < REQ; k++) begin
        if (req_ack[k]) begin
          req_valid[k] = 1'b0;
        end else if (!req_valid[k] && $urandom_range(0, 5) == 0) begin
          req_cmd[k*PC_W +: PC_W] = rand_cmd();
          req_valid[k] = 1'b1;
        end
      end
      // Alternate between a chattering executer and one stuck ready, so the
      // watchdog path is exercised too.
      if ((cyc_n / 100) % 3 == 2) exec_ready = 1'b1;
      else                        exec_ready = ($urandom_range(0, 2) != 0);
      model_step();
    end
  endtask

  initial begin
    usr_rst    = 1'b1;
    req_valid  = '0;
    req_cmd    = '0;
    exec_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_watchdog();
    test_exec_busy();
    test_reset_mid_busy();
    test_cmd_latch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
